// File: rtl/design_select_sequencer_pkg.sv
// design_select_sequencer_pkg: shared select width, default slot population mask and sequencer states
package design_select_sequencer_pkg;
  localparam int SEL_W = 6;
  localparam logic [2**SEL_W-1:0] POPULATED_DEF = 64'h0000_0000_0000_0026;
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_DRAIN    = 2'd1;
  localparam logic [1:0] ST_RST_HOLD = 2'd2;
  typedef enum logic [1:0] {
    RUN      = ST_RUN,
    DRAIN    = ST_DRAIN,
    RST_HOLD = ST_RST_HOLD
  } seq_state_t;
endpackage

// File: rtl/design_select_sequencer_if.sv
// design_select_sequencer_if: pin-side select input and mux-side control outputs
// slave  (sequencer): sel_raw in; des_sel, des_reset_force, out_enable, busy, sel_err out
// master (driver/observer): the mirror image
interface design_select_sequencer_if;
  import design_select_sequencer_pkg::*;
  logic [SEL_W-1:0] sel_raw;
  logic [SEL_W-1:0] des_sel;
  logic             des_reset_force;
  logic             out_enable;
  logic             busy;
  logic             sel_err;
  modport slave (input sel_raw, output des_sel, des_reset_force, out_enable, busy, sel_err);
  modport master(output sel_raw, input des_sel, des_reset_force, out_enable, busy, sel_err);
endinterface

// File: rtl/design_select_sequencer_sel_debouncer.sv
// sel_debouncer: 2-flop synchroniser on the select pins plus a stability counter on the synced value
// clock, reset : clock and async active-high reset
// sel_raw      : unsynchronised select pins
// cand         : last synced select value seen
// stable       : cand has been unchanged for DEBOUNCE_CYCLES cycles
module sel_debouncer
  import design_select_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [SEL_W-1:0] sel_raw,
  output logic [SEL_W-1:0] cand,
  output logic             stable
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [SEL_W-1:0] s1, s2;
  logic [CW-1:0]    cnt;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      cand <= '0;
      cnt  <= '0;
    end else begin
      s1   <= sel_raw;
      s2   <= s1;
      cand <= s2;
      cnt  <= (s2 != cand) ? '0 : (cnt == CW'(DEBOUNCE_CYCLES)) ? cnt : cnt + 1'b1;
    end
  assign stable = cnt == CW'(DEBOUNCE_CYCLES);
endmodule

// File: rtl/design_select_sequencer.sv
// design_select_sequencer: debounced, gated and reset-sequenced switching of the active design slot
// clock, reset : clock and async active-high reset
// bus (slave)  : sel_raw pins in; des_sel, des_reset_force, out_enable, busy, sel_err to the mux
module design_select_sequencer
  import design_select_sequencer_pkg::*;
#(
  parameter int                   DEBOUNCE_CYCLES = 16,
  parameter int                   DRAIN_CYCLES    = 2,
  parameter int                   RESET_CYCLES    = 4,
  parameter logic [2**SEL_W-1:0]  POPULATED       = POPULATED_DEF
) (
  input logic                      clock,
  input logic                      reset,
  design_select_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2((DRAIN_CYCLES > RESET_CYCLES ? DRAIN_CYCLES : RESET_CYCLES) + 1);
  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] cand;
  logic             stable, req, pop, err_seen;
  sel_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clock  (clock),
    .reset  (reset),
    .sel_raw(bus.sel_raw),
    .cand   (cand),
    .stable (stable)
  );
  assign req = stable && cand != bus.des_sel;
  assign pop = POPULATED[cand];
  // a new cand always restarts the stability count, so !stable marks a changed request
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state       <= RST_HOLD;
      cnt         <= CNT_W'(RESET_CYCLES - 1);
      bus.des_sel <= '0;
      bus.sel_err <= 1'b0;
      err_seen    <= 1'b0;
    end else begin
      bus.sel_err <= state == RUN && req && !pop && !err_seen;
      err_seen    <= stable && (err_seen || (state == RUN && req && !pop));
      case (state)
        RUN:
          if (req && pop) begin
            state <= DRAIN;
            cnt   <= CNT_W'(DRAIN_CYCLES - 1);
          end
        DRAIN:
          if (cnt == '0) begin
            state <= RST_HOLD;
            cnt   <= CNT_W'(RESET_CYCLES - 1);
            if (stable && pop) bus.des_sel <= cand;
          end else cnt <= cnt - 1'b1;
        default:
          if (cnt == '0) state <= RUN;
          else cnt <= cnt - 1'b1;
      endcase
    end
  assign bus.out_enable      = state == RUN;
  assign bus.busy            = state != RUN;
  assign bus.des_reset_force = state == RST_HOLD;
endmodule

// File: tb/tb_design_select_sequencer.sv
// tb_design_select_sequencer: randomized scoreboard bench with an event-timing reference model
module tb_design_select_sequencer;
  import design_select_sequencer_pkg::*;
  localparam int DEB = 16, DRN = 2, RSTC = 4;
  localparam logic [63:0] POP = 64'h26;
  localparam int K_FALL = 0, K_RISE = 1, K_DESEL = 2, K_ERR = 3;
  typedef struct { int kind; int val; int cyc; } ev_t;
  logic clock = 0, reset = 0;
  always #5 clock = ~clock;
  design_select_sequencer_if bus();
  design_select_sequencer dut(.clock(clock), .reset(reset), .bus(bus));
  ev_t q[$];
  int cyc = 0, checks = 0, failures = 0;
  int cur = 0, ready = 0, last = 0;
  logic p_oe = 0;
  logic [5:0] p_ds = 0;
  always @(posedge clock) cyc++;
  function automatic int mx(int a, int b);
    return a > b ? a : b;
  endfunction
  task automatic check(string name, int got, int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d cyc=%0d", name, got, exp, cyc);
    end
  endtask
  task automatic push(int k, int v, int c);
    ev_t e;
    e.kind = k; e.val = v; e.cyc = c;
    q.push_back(e);
  endtask
  task automatic got_ev(int k, int v);
    ev_t x;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event kind=%0d val=%0d cyc=%0d (none expected)", k, v, cyc);
    end else begin
      x = q.pop_front();
      if (x.kind != k || x.val != v || x.cyc != cyc) begin
        failures++;
        $display("FAIL event got kind=%0d val=%0d cyc=%0d expected kind=%0d val=%0d cyc=%0d",
                 k, v, cyc, x.kind, x.val, x.cyc);
      end
    end
  endtask
  // A value first sampled at edge t is stable after edge t+2+DEB; the sequencer acts
  // on the first edge after that at which it is back in RUN.
  task automatic apply(int v, int t);
    int e;
    if (v == cur) return;
    e = mx(t + 2 + DEB, ready) + 1;
    if (POP[v]) begin
      push(K_FALL, cur, e);
      push(K_DESEL, v, e + DRN);
      push(K_RISE, v, e + DRN + RSTC);
      ready = e + DRN + RSTC;
      cur = v;
    end else push(K_ERR, cur, e);
  endtask
  task automatic drive(int v, output int t);
    @(negedge clock);
    bus.sel_raw = 6'(v);
    t = cyc + 1;
    last = t;
  endtask
  task automatic settle();
    int tgt;
    tgt = mx(last + DEB + 30, ready + 5);
    while (cyc < tgt) @(negedge clock);
  endtask
  task automatic reset_checks(string tag);
    check({tag, "_des_sel"}, bus.des_sel, 0);
    check({tag, "_force"}, bus.des_reset_force, 1);
    check({tag, "_out_en"}, bus.out_enable, 0);
    check({tag, "_busy"}, bus.busy, 1);
    check({tag, "_sel_err"}, bus.sel_err, 0);
  endtask
  task automatic after_release(int v);
    int t0;
    t0 = cyc + 1;
    cur = 0;
    ready = t0 + RSTC - 1;
    push(K_RISE, 0, ready);
    apply(v, t0);
    last = t0;
  endtask
  task automatic do_switch(int v);
    int t;
    drive(v, t);
    apply(v, t);
    settle();
  endtask
  task automatic do_glitch(int v, int len);
    int t;
    drive(v, t);
    repeat (len - 1) @(negedge clock);
    drive(cur, t);
    settle();
  endtask
  task automatic do_unpop(int v, int hold);
    int t;
    drive(v, t);
    apply(v, t);
    repeat (hold) @(negedge clock);
    drive(cur, t);
    settle();
  endtask
  task automatic do_double(int v1, int v2, int r);
    int t, t2, home;
    home = cur;
    drive(v1, t);
    apply(v1, t);
    while (cyc < t + DEB + 2 + r) @(negedge clock);
    drive(v2, t2);
    apply(v2, t2);
    settle();
    if (!POP[v2]) begin
      drive(cur, t2);
      settle();
    end
  endtask
  function automatic int pick_pop();
    int v;
    do v = $urandom_range(0, 63); while (!POP[v] || v == cur);
    return v;
  endfunction
  function automatic int pick_unpop();
    int v;
    do v = $urandom_range(0, 63); while (POP[v]);
    return v;
  endfunction
  always @(negedge clock)
    if (reset) begin
      p_oe = 0;
      p_ds = 0;
    end else begin
      if (bus.out_enable !== p_oe) got_ev(bus.out_enable ? K_RISE : K_FALL, bus.des_sel);
      if (bus.des_sel !== p_ds) got_ev(K_DESEL, bus.des_sel);
      if (bus.sel_err) begin
        got_ev(K_ERR, bus.des_sel);
        check("sel_err_busy", bus.busy, 0);
      end
      p_oe = bus.out_enable;
      p_ds = bus.des_sel;
    end
  initial begin
    int v, v2, t;
    bus.sel_raw = 6'd1;
    #1 reset = 1;
    #2 reset_checks("rst");
    repeat (3) @(negedge clock);
    reset = 0;
    after_release(1);
    settle();
    do_glitch(5, 10);
    do_unpop(9, 50);
    do_switch(2);
    do_switch(1);
    do_double(2, 5, 1);
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          do v = $urandom_range(0, 63); while (v == cur);
          do_glitch(v, $urandom_range(1, DEB));
        end
        1: do_switch(pick_pop());
        2: do_unpop(pick_unpop(), $urandom_range(20, 60));
        default: begin
          v = pick_pop();
          do v2 = $urandom_range(0, 63); while (v2 == v);
          do_double(v, v2, $urandom_range(0, 4));
        end
      endcase
    end
    v = pick_pop();
    drive(v, t);
    push(K_FALL, cur, t + DEB + 3);
    push(K_DESEL, v, t + DEB + 3 + DRN);
    while (cyc < t + DEB + 3 + DRN + 1) @(negedge clock);
    @(posedge clock);
    #2 reset = 1;
    #1 reset_checks("mid_rst");
    repeat (2) @(negedge clock);
    reset = 0;
    after_release(v);
    settle();
    check("queue_empty", q.size(), 0);
    check("final_des_sel", bus.des_sel, cur);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
